// File: rtl/bcd_entry_ctrl_if.sv
// Handshake bundle between the entry controller and its neighbours: switch/button
// inputs plus the accepted-digit, committed-sample and strobe outputs.
interface bcd_entry_ctrl_if;
  logic       key_n;
  logic       sign_on;
  logic [3:0] bcd_num;
  logic [2:0] bcd_press;
  logic [3:0] curr_ones, curr_tens, curr_huns;
  logic [3:0] temp_ones, temp_tens, temp_huns;
  logic       temp_neg;
  logic [3:0] prev_ones, prev_tens, prev_huns;
  logic       prev_neg;
  logic       got_value;
  logic       entry_err;
  logic       sign_mode_changed;

  modport master (
    output key_n, sign_on, bcd_num,
    input  bcd_press, curr_ones, curr_tens, curr_huns,
           temp_ones, temp_tens, temp_huns, temp_neg,
           prev_ones, prev_tens, prev_huns, prev_neg,
           got_value, entry_err, sign_mode_changed
  );

  modport slave (
    input  key_n, sign_on, bcd_num,
    output bcd_press, curr_ones, curr_tens, curr_huns,
           temp_ones, temp_tens, temp_huns, temp_neg,
           prev_ones, prev_tens, prev_huns, prev_neg,
           got_value, entry_err, sign_mode_changed
  );
endinterface

// File: rtl/bcd_entry_ctrl.sv
// Debounced three-digit BCD entry sequencer that commits a signed temperature and
// keeps the previous committed sample alongside it.
module bcd_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  bcd_entry_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ONES = 2'd0,
    TENS = 2'd1,
    HUNS = 2'd2,
    SHOW = 2'd3
  } state_t;

  logic             syncStage1_q, syncStage2_q;
  logic             keyLevel_q, keyLevel_d;
  logic             pressEvt_q, pressEvt_d;
  logic [CNT_W-1:0] stableCnt_q, stableCnt_d;

  state_t     state_q;
  logic [3:0] currOnes_q, currTens_q, currHuns_q;
  logic [3:0] tempOnes_q, tempTens_q, tempHuns_q;
  logic [3:0] prevOnes_q, prevTens_q, prevHuns_q;
  logic       tempNeg_q, prevNeg_q;
  logic       gotValue_q, entryErr_q, signChanged_q;
  logic       signSample_q, signSamplePrev_q;
  logic       digitOk, commitNonZero;

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any match restarts it.
  always_comb begin
    stableCnt_d = '0;
    keyLevel_d  = keyLevel_q;
    pressEvt_d  = 1'b0;
    if (syncStage2_q != keyLevel_q) begin
      if (stableCnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        keyLevel_d = syncStage2_q;
        pressEvt_d = ~syncStage2_q;
      end else begin
        stableCnt_d = stableCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      syncStage1_q <= 1'b1;
      syncStage2_q <= 1'b1;
      keyLevel_q   <= 1'b1;
      pressEvt_q   <= 1'b0;
      stableCnt_q  <= '0;
    end else begin
      syncStage1_q <= bus.key_n;
      syncStage2_q <= syncStage1_q;
      keyLevel_q   <= keyLevel_d;
      pressEvt_q   <= pressEvt_d;
      stableCnt_q  <= stableCnt_d;
    end
  end

  assign digitOk       = (bus.bcd_num <= 4'd9);
  assign commitNonZero = |{bus.bcd_num, currTens_q, currOnes_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ONES;
      currOnes_q       <= '0;
      currTens_q       <= '0;
      currHuns_q       <= '0;
      tempOnes_q       <= '0;
      tempTens_q       <= '0;
      tempHuns_q       <= '0;
      tempNeg_q        <= 1'b0;
      prevOnes_q       <= '0;
      prevTens_q       <= '0;
      prevHuns_q       <= '0;
      prevNeg_q        <= 1'b0;
      gotValue_q       <= 1'b0;
      entryErr_q       <= 1'b0;
      signChanged_q    <= 1'b0;
      signSample_q     <= 1'b0;
      signSamplePrev_q <= 1'b0;
    end else begin
      gotValue_q       <= 1'b0;
      entryErr_q       <= 1'b0;
      signSample_q     <= bus.sign_on;
      signSamplePrev_q <= signSample_q;
      signChanged_q    <= (state_q == SHOW) && (signSample_q != signSamplePrev_q);
      if (pressEvt_q) begin
        case (state_q)
          ONES: begin
            if (digitOk) begin
              currOnes_q <= bus.bcd_num;
              state_q    <= TENS;
            end else begin
              entryErr_q <= 1'b1;
            end
          end
          TENS: begin
            if (digitOk) begin
              currTens_q <= bus.bcd_num;
              state_q    <= HUNS;
            end else begin
              entryErr_q <= 1'b1;
            end
          end
          HUNS: begin
            // Commit: the hundreds digit goes straight into temp_* on the same edge.
            if (digitOk) begin
              currHuns_q <= bus.bcd_num;
              prevOnes_q <= tempOnes_q;
              prevTens_q <= tempTens_q;
              prevHuns_q <= tempHuns_q;
              prevNeg_q  <= tempNeg_q;
              tempOnes_q <= currOnes_q;
              tempTens_q <= currTens_q;
              tempHuns_q <= bus.bcd_num;
              tempNeg_q  <= bus.sign_on & commitNonZero;
              gotValue_q <= 1'b1;
              state_q    <= SHOW;
            end else begin
              entryErr_q <= 1'b1;
            end
          end
          SHOW: begin
            currOnes_q <= '0;
            currTens_q <= '0;
            currHuns_q <= '0;
            state_q    <= ONES;
          end
        endcase
      end
    end
  end

  assign bus.bcd_press         = {1'b0, state_q};
  assign bus.curr_ones         = currOnes_q;
  assign bus.curr_tens         = currTens_q;
  assign bus.curr_huns         = currHuns_q;
  assign bus.temp_ones         = tempOnes_q;
  assign bus.temp_tens         = tempTens_q;
  assign bus.temp_huns         = tempHuns_q;
  assign bus.temp_neg          = tempNeg_q;
  assign bus.prev_ones         = prevOnes_q;
  assign bus.prev_tens         = prevTens_q;
  assign bus.prev_huns         = prevHuns_q;
  assign bus.prev_neg          = prevNeg_q;
  assign bus.got_value         = gotValue_q;
  assign bus.entry_err         = entryErr_q;
  assign bus.sign_mode_changed = signChanged_q;

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Directed self-checking bench for bcd_entry_ctrl with a short debounce window.
module tb_bcd_entry_ctrl;
  logic clk;
  logic rst;
  int   passCount  = 0;
  int   checkCount = 0;

  bcd_entry_ctrl_if bus ();

  bcd_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Hold the key low until the FSM edge (7 edges with a 4-cycle window).
  task automatic applyStimulus(input logic [3:0] digit);
    bus.bcd_num = digit;
    bus.key_n   = 1'b0;
    repeat (7) tick();
  endtask

  task automatic releaseKey();
    bus.key_n = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    rst         = 1'b1;
    bus.key_n   = 1'b1;
    bus.sign_on = 1'b0;
    bus.bcd_num = 4'd0;
    repeat (2) tick();

    checkOutput("reset_press", 12'(bus.bcd_press), 12'd0);
    checkOutput("reset_curr", {bus.curr_huns, bus.curr_tens, bus.curr_ones}, 12'h000);
    checkOutput("reset_temp", {bus.temp_huns, bus.temp_tens, bus.temp_ones}, 12'h000);
    checkOutput("reset_prev", {bus.prev_huns, bus.prev_tens, bus.prev_ones}, 12'h000);
    checkOutput("reset_strobes", 12'({bus.got_value, bus.entry_err, bus.sign_mode_changed, bus.temp_neg, bus.prev_neg}), 12'd0);
    rst = 1'b0;
    tick();

    $display("[TB] clean press latency");
    bus.bcd_num = 4'd7;
    bus.key_n   = 1'b0;
    repeat (6) tick();
    checkOutput("lat_edge6_press", 12'(bus.bcd_press), 12'd0);
    tick();
    checkOutput("lat_edge7_press", 12'(bus.bcd_press), 12'd1);
    checkOutput("lat_edge7_ones", 12'(bus.curr_ones), 12'd7);
    releaseKey();

    $display("[TB] rejected digit in TENS");
    applyStimulus(4'hC);
    checkOutput("err_strobe", 12'(bus.entry_err), 12'd1);
    checkOutput("err_press", 12'(bus.bcd_press), 12'd1);
    checkOutput("err_curr", {bus.curr_huns, bus.curr_tens, bus.curr_ones}, 12'h007);
    checkOutput("err_no_got", 12'(bus.got_value), 12'd0);
    tick();
    checkOutput("err_one_cycle", 12'(bus.entry_err), 12'd0);
    releaseKey();

    $display("[TB] bouncing key");
    bus.bcd_num = 4'd3;
    for (int i = 0; i < 5; i++) begin
      bus.key_n = 1'b0;
      repeat (2) tick();
      bus.key_n = 1'b1;
      repeat (2) tick();
      checkOutput("bounce_hold", 12'(bus.bcd_press), 12'd1);
    end
    bus.key_n = 1'b0;
    repeat (6) tick();
    checkOutput("bounce_edge6", 12'(bus.bcd_press), 12'd1);
    tick();
    checkOutput("bounce_edge7", 12'(bus.bcd_press), 12'd2);
    checkOutput("bounce_tens", 12'(bus.curr_tens), 12'd3);
    repeat (10) tick();
    checkOutput("hold_no_repeat", 12'(bus.bcd_press), 12'd2);
    releaseKey();

    $display("[TB] reset mid-entry");
    rst = 1'b1;
    tick();
    checkOutput("midrst_press", 12'(bus.bcd_press), 12'd0);
    checkOutput("midrst_curr", {bus.curr_huns, bus.curr_tens, bus.curr_ones}, 12'h000);
    checkOutput("midrst_got", 12'(bus.got_value), 12'd0);
    rst = 1'b0;
    tick();

    $display("[TB] first commit -125");
    bus.sign_on = 1'b1;
    repeat (3) tick();
    checkOutput("sign_outside_show", 12'(bus.sign_mode_changed), 12'd0);
    applyStimulus(4'd5);
    releaseKey();
    applyStimulus(4'd2);
    releaseKey();
    applyStimulus(4'd1);
    checkOutput("c1_got", 12'(bus.got_value), 12'd1);
    checkOutput("c1_err", 12'(bus.entry_err), 12'd0);
    checkOutput("c1_press", 12'(bus.bcd_press), 12'd3);
    checkOutput("c1_temp", {bus.temp_huns, bus.temp_tens, bus.temp_ones}, 12'h125);
    checkOutput("c1_temp_neg", 12'(bus.temp_neg), 12'd1);
    checkOutput("c1_prev", {bus.prev_huns, bus.prev_tens, bus.prev_ones}, 12'h000);
    checkOutput("c1_prev_neg", 12'(bus.prev_neg), 12'd0);
    tick();
    checkOutput("c1_got_one_cycle", 12'(bus.got_value), 12'd0);
    releaseKey();

    $display("[TB] SHOW press then commit +003");
    applyStimulus(4'hF);
    checkOutput("show_err", 12'(bus.entry_err), 12'd0);
    checkOutput("show_press", 12'(bus.bcd_press), 12'd0);
    checkOutput("show_curr", {bus.curr_huns, bus.curr_tens, bus.curr_ones}, 12'h000);
    checkOutput("show_temp_kept", {bus.temp_huns, bus.temp_tens, bus.temp_ones}, 12'h125);
    releaseKey();
    bus.sign_on = 1'b0;
    repeat (3) tick();
    applyStimulus(4'd3);
    releaseKey();
    applyStimulus(4'd0);
    releaseKey();
    applyStimulus(4'd0);
    checkOutput("c2_got", 12'(bus.got_value), 12'd1);
    checkOutput("c2_temp", {bus.temp_huns, bus.temp_tens, bus.temp_ones}, 12'h003);
    checkOutput("c2_temp_neg", 12'(bus.temp_neg), 12'd0);
    checkOutput("c2_prev", {bus.prev_huns, bus.prev_tens, bus.prev_ones}, 12'h125);
    checkOutput("c2_prev_neg", 12'(bus.prev_neg), 12'd1);
    releaseKey();

    $display("[TB] negative zero and sign toggle");
    applyStimulus(4'd9);
    releaseKey();
    bus.sign_on = 1'b1;
    repeat (3) tick();
    applyStimulus(4'd0);
    releaseKey();
    applyStimulus(4'd0);
    releaseKey();
    applyStimulus(4'd0);
    checkOutput("c3_got", 12'(bus.got_value), 12'd1);
    checkOutput("c3_temp", {bus.temp_huns, bus.temp_tens, bus.temp_ones}, 12'h000);
    checkOutput("c3_neg_zero", 12'(bus.temp_neg), 12'd0);
    releaseKey();
    bus.sign_on = 1'b0;
    tick();
    checkOutput("smc_edge1", 12'(bus.sign_mode_changed), 12'd0);
    tick();
    checkOutput("smc_edge2", 12'(bus.sign_mode_changed), 12'd1);
    checkOutput("smc_temp_neg", 12'(bus.temp_neg), 12'd0);
    tick();
    checkOutput("smc_edge3", 12'(bus.sign_mode_changed), 12'd0);

    $display("[TB] reset after commits");
    rst = 1'b1;
    tick();
    checkOutput("finrst_prev", {bus.prev_huns, bus.prev_tens, bus.prev_ones}, 12'h000);
    checkOutput("finrst_press", 12'(bus.bcd_press), 12'd0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
